// File: rtl/dram_axi_calib_guard.sv
// AXI4 guard between the CDC port and the DRAM controller: holds traffic until calibration,
// answers out-of-window requests with SLVERR, and forwards the rest with the upper address bits cleared.
package dram_axi_calib_guard_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  user;
  } axi_ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [3:0]  user;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [3:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  user;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;
endpackage

module dram_axi_calib_guard #(
  parameter type axi_req_t      = dram_axi_calib_guard_pkg::axi_req_t,
  parameter type axi_resp_t     = dram_axi_calib_guard_pkg::axi_resp_t,
  parameter int  AddrWidth      = 64,
  parameter int  DramAddrWidth  = 30,
  parameter int  MaxOutstanding = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        calib_done_i,
  input  axi_req_t    slv_req_i,
  output axi_resp_t   slv_rsp_o,
  output axi_req_t    mst_req_o,
  input  axi_resp_t   mst_rsp_i,
  output logic        calib_ok_o,
  output logic [15:0] err_cnt_o
);
  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [AddrWidth-1:0] AddrMask =
    {{(AddrWidth-DramAddrWidth){1'b0}}, {DramAddrWidth{1'b1}}};

  typedef enum logic [2:0] {W_IDLE, W_FWD, W_DRAIN, W_SINK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_ERR} r_state_t;

  w_state_t w_state_q;
  r_state_t r_state_q;
  logic calib_q;
  logic [CntWidth-1:0] wr_cnt_q, rd_cnt_q;
  logic [15:0] err_cnt_q;
  logic [$bits(slv_req_i.aw.id)-1:0] w_id_q;
  logic [$bits(slv_req_i.ar.id)-1:0] r_id_q;
  logic [7:0] r_len_q, r_beat_q;

  logic aw_oor, ar_oor, aw_fwd_ok, ar_fwd_ok, aw_rej, ar_rej;
  logic aw_hs, b_hs, ar_hs, r_last_hs;
  logic [16:0] err_sum;

  assign aw_oor    = |slv_req_i.aw.addr[AddrWidth-1:DramAddrWidth];
  assign ar_oor    = |slv_req_i.ar.addr[AddrWidth-1:DramAddrWidth];
  assign aw_fwd_ok = calib_q && (w_state_q == W_IDLE) && !aw_oor && (wr_cnt_q < CntMax);
  assign ar_fwd_ok = calib_q && (r_state_q == R_IDLE) && !ar_oor && (rd_cnt_q < CntMax);
  assign aw_rej    = calib_q && (w_state_q == W_IDLE) && slv_req_i.aw_valid && aw_oor;
  assign ar_rej    = calib_q && (r_state_q == R_IDLE) && slv_req_i.ar_valid && ar_oor;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw.addr  = slv_req_i.aw.addr & AddrMask;
    mst_req_o.ar.addr  = slv_req_i.ar.addr & AddrMask;
    mst_req_o.aw_valid = aw_fwd_ok && slv_req_i.aw_valid;
    mst_req_o.w_valid  = calib_q && (w_state_q == W_FWD) && slv_req_i.w_valid;
    mst_req_o.b_ready  = calib_q && (w_state_q != W_RESP) && slv_req_i.b_ready;
    mst_req_o.ar_valid = ar_fwd_ok && slv_req_i.ar_valid;
    mst_req_o.r_ready  = calib_q && (r_state_q != R_ERR) && slv_req_i.r_ready;

    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.aw_ready = aw_rej || (aw_fwd_ok && mst_rsp_i.aw_ready);
    slv_rsp_o.ar_ready = ar_rej || (ar_fwd_ok && mst_rsp_i.ar_ready);
    slv_rsp_o.w_ready  = calib_q && (((w_state_q == W_FWD) && mst_rsp_i.w_ready) ||
                                     (w_state_q == W_SINK));
    slv_rsp_o.b_valid  = calib_q && mst_rsp_i.b_valid;
    slv_rsp_o.r_valid  = calib_q && mst_rsp_i.r_valid;
    if (w_state_q == W_RESP) begin
      slv_rsp_o.b       = '0;
      slv_rsp_o.b.id    = w_id_q;
      slv_rsp_o.b.resp  = 2'b10;
      slv_rsp_o.b_valid = 1'b1;
    end
    if (r_state_q == R_ERR) begin
      slv_rsp_o.r       = '0;
      slv_rsp_o.r.id    = r_id_q;
      slv_rsp_o.r.resp  = 2'b10;
      slv_rsp_o.r.last  = (r_beat_q == r_len_q);
      slv_rsp_o.r_valid = 1'b1;
    end
  end

  assign aw_hs     = mst_req_o.aw_valid && mst_rsp_i.aw_ready;
  assign b_hs      = mst_rsp_i.b_valid && mst_req_o.b_ready;
  assign ar_hs     = mst_req_o.ar_valid && mst_rsp_i.ar_ready;
  assign r_last_hs = mst_rsp_i.r_valid && mst_req_o.r_ready && mst_rsp_i.r.last;
  assign err_sum   = {1'b0, err_cnt_q} + 17'(aw_rej) + 17'(ar_rej);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      calib_q   <= 1'b0;
      err_cnt_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      if (calib_done_i) calib_q <= 1'b1;
      err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      case ({aw_hs, b_hs})
        2'b10:   wr_cnt_q <= wr_cnt_q + CntOne;
        2'b01:   wr_cnt_q <= wr_cnt_q - CntOne;
        default: wr_cnt_q <= wr_cnt_q;
      endcase
      case ({ar_hs, r_last_hs})
        2'b10:   rd_cnt_q <= rd_cnt_q + CntOne;
        2'b01:   rd_cnt_q <= rd_cnt_q - CntOne;
        default: rd_cnt_q <= rd_cnt_q;
      endcase
    end
  end

  // The error B waits for all forwarded writes to retire so it cannot overtake a same-ID response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            w_state_q <= W_FWD;
          end else if (aw_rej) begin
            w_id_q    <= slv_req_i.aw.id;
            w_state_q <= W_DRAIN;
          end
        end
        W_FWD:   if (slv_req_i.w_valid && mst_rsp_i.w_ready && slv_req_i.w.last) w_state_q <= W_IDLE;
        W_DRAIN: if (wr_cnt_q == '0) w_state_q <= W_SINK;
        W_SINK:  if (slv_req_i.w_valid && slv_req_i.w.last) w_state_q <= W_RESP;
        W_RESP:  if (slv_req_i.b_ready) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_rej) begin
            r_id_q    <= slv_req_i.ar.id;
            r_len_q   <= slv_req_i.ar.len;
            r_beat_q  <= '0;
            r_state_q <= R_DRAIN;
          end
        end
        R_DRAIN: if (rd_cnt_q == '0) r_state_q <= R_ERR;
        R_ERR: begin
          if (slv_req_i.r_ready) begin
            if (r_beat_q == r_len_q) r_state_q <= R_IDLE;
            else                     r_beat_q  <= r_beat_q + 8'd1;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign calib_ok_o = calib_q;
  assign err_cnt_o  = err_cnt_q;
endmodule
